// File: rtl/idex_stage_reg.sv
// ID/EX pipeline stage register: two-entry skid buffer between decode and
// execute, with synchronous flush and a saturating back-pressure counter.
// id_ready comes straight from a state flop, so execute stalls never reach
// combinationally back into decode.
//
// Handshake: a bundle moves on a side only in a cycle where both valid and
// ready are high at the rising edge. Valid never depends on ready. Once
// ex_valid is high, the ex_* payload holds until it is consumed or flushed.
module idex_stage_reg #(
   parameter int XLEN       = 32,
   parameter int CTRL_W     = 16,
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  id_valid,
   output logic                  id_ready,
   input  logic [XLEN-1:0]       id_pc,
   input  logic [XLEN-1:0]       id_rs1_val,
   input  logic [XLEN-1:0]       id_rs2_val,
   input  logic [XLEN-1:0]       id_imm,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic [CTRL_W-1:0]     id_ctrl,
   output logic                  ex_valid,
   input  logic                  ex_ready,
   output logic [XLEN-1:0]       ex_pc,
   output logic [XLEN-1:0]       ex_rs1_val,
   output logic [XLEN-1:0]       ex_rs2_val,
   output logic [XLEN-1:0]       ex_imm,
   output logic [REG_ADDR_W-1:0] ex_rd,
   output logic [CTRL_W-1:0]     ex_ctrl,
   input  logic                  flush,
   input  logic                  stall_clr,
   output logic [CNT_W-1:0]      stall_cnt,
   output logic [1:0]            dbg_state
);

   localparam int PAY_W = 4*XLEN + REG_ADDR_W + CTRL_W;

   // Bit 0 is the main-entry valid and bit 1 the skid-entry valid, so both
   // handshake outputs decode from a single flop each. 2'b10 is unreachable.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b01,
      ST_FULL  = 2'b11
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic             main_load_in;
   logic             main_load_skid;
   logic             skid_load;
   logic             accept;
   logic             consume;
   logic [PAY_W-1:0] id_pay;
   logic [PAY_W-1:0] main_pay;
   logic [PAY_W-1:0] skid_pay;

   assign id_pay  = {id_pc, id_rs1_val, id_rs2_val, id_imm, id_rd, id_ctrl};
   assign accept  = id_valid & id_ready;
   assign consume = ex_valid & ex_ready;

   // State register: occupancy of the two entries.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and entry load selects; flush overrides accept and consume.
   always_comb begin
      state_d        = state_q;
      main_load_in   = 1'b0;
      main_load_skid = 1'b0;
      skid_load      = 1'b0;
      if (flush) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (accept) begin
                  state_d      = ST_ONE;
                  main_load_in = 1'b1;
               end
            end
            ST_ONE: begin
               if (accept && consume) begin
                  main_load_in = 1'b1;
               end else if (accept) begin
                  state_d   = ST_FULL;
                  skid_load = 1'b1;
               end else if (consume) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_FULL: begin
               // id_ready is low here, so only a consume can happen.
               if (consume) begin
                  state_d        = ST_ONE;
                  main_load_skid = 1'b1;
               end
            end
            default: begin
               state_d = ST_EMPTY;
            end
         endcase
      end
   end

   // Handshake outputs decoded directly from the state flop.
   always_comb begin
      ex_valid  = state_q[0];
      id_ready  = ~state_q[1];
      dbg_state = state_q;
   end

   // Payload storage for main and skid entries; cleared only by reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         main_pay <= '0;
         skid_pay <= '0;
      end else begin
         if (main_load_in) begin
            main_pay <= id_pay;
         end else if (main_load_skid) begin
            main_pay <= skid_pay;
         end
         if (skid_load) begin
            skid_pay <= id_pay;
         end
      end
   end

   assign {ex_pc, ex_rs1_val, ex_rs2_val, ex_imm, ex_rd, ex_ctrl} = main_pay;

   // Stall counter: counts stalled cycles, saturates, clear wins over count.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stall_cnt <= '0;
      end else if (stall_clr) begin
         stall_cnt <= '0;
      end else if (ex_valid && !ex_ready && (stall_cnt != {CNT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule
